// File: rtl/agc_sar_tracker.sv
// AGC loop controller: binary-search gain acquisition, then HOLD, or +/-1 LSB tracking when AGC_TRACK_EN is defined.
// gain_code settles 2 cycles after the window-completing valid sample; gaps in sample_valid stall the window.
module agc_sar_tracker #(
  parameter int                DATA_W     = 16,
  parameter int                GAIN_W     = 6,
  parameter int                DWELL_W    = 4,
  parameter int                SETTLE_CYC = 8,
  parameter logic [DATA_W-1:0] HI_THRESH  = 16'd12000,
  parameter logic [DATA_W-1:0] LO_THRESH  = 16'd4000
) (
  input  logic                     clk,
  input  logic                     RESETn,
  input  logic                     start,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     overload,
  output logic [GAIN_W-1:0]        gain_code,
  output logic                     gain_update,
  output logic                     busy,
  output logic                     locked
);

  localparam int KW = $clog2(GAIN_W + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [GAIN_W-1:0] MID      = {1'b1, {(GAIN_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  if (LO_THRESH >= HI_THRESH) begin : g_bad_thresh
    $error("agc_sar_tracker: LO_THRESH must be below HI_THRESH");
  end
  if (SETTLE_CYC < 1 || DWELL_W < 1 || GAIN_W < 2) begin : g_bad_size
    $error("agc_sar_tracker: SETTLE_CYC, DWELL_W must be >= 1 and GAIN_W >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DECIDE,
    S_HOLD
  } state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic [SW-1:0]       settle_cnt;
  logic [DWELL_W-1:0]  win_cnt;
  logic [DATA_W-2:0]   peak;
  logic                hot_flag;
  logic [DATA_W-1:0]   neg_sample;
  logic [DATA_W-2:0]   mag;
  logic                hot;
  logic [GAIN_W-1:0]   sar_next;
  logic [GAIN_W-1:0]   next_gain;
  logic                gain_chg;

  // Saturating magnitude: the most negative code would otherwise wrap to zero.
  always_comb begin
    neg_sample = -sample;
    if (!sample[DATA_W-1])
      mag = sample[DATA_W-2:0];
    else if (sample == MOST_NEG)
      mag = '1;
    else
      mag = neg_sample[DATA_W-2:0];
  end

  assign hot = hot_flag | ({1'b0, peak} >= HI_THRESH);

  always_comb begin
    sar_next = gain_code;
    for (int i = 0; i < GAIN_W; i++) begin
      if (KW'(i) == k && hot) sar_next[i] = 1'b0;
      if (KW'(i + 1) == k)    sar_next[i] = 1'b1;
    end
  end

`ifdef AGC_TRACK_EN
  logic              trk;
  logic              cold;
  logic [GAIN_W-1:0] trk_next;

  assign cold = !hot && ({1'b0, peak} < LO_THRESH);

  always_comb begin
    trk_next = gain_code;
    if (hot) begin
      if (gain_code != '0) trk_next = gain_code - 1'b1;
    end else if (cold) begin
      if (gain_code != '1) trk_next = gain_code + 1'b1;
    end
  end

  assign next_gain = trk ? trk_next : sar_next;
`else
  assign next_gain = sar_next;
`endif

  assign gain_chg = (next_gain != gain_code);

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state       <= S_IDLE;
      gain_code   <= MID;
      gain_update <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      k           <= '0;
      settle_cnt  <= '0;
      win_cnt     <= '0;
      peak        <= '0;
      hot_flag    <= 1'b0;
`ifdef AGC_TRACK_EN
      trk         <= 1'b0;
`endif
    end else begin
      gain_update <= 1'b0;
      if (start) begin
        state       <= S_SETTLE;
        gain_code   <= MID;
        gain_update <= 1'b1;
        busy        <= 1'b1;
        locked      <= 1'b0;
        k           <= KW'(GAIN_W - 1);
        settle_cnt  <= '0;
        win_cnt     <= '0;
        peak        <= '0;
        hot_flag    <= 1'b0;
`ifdef AGC_TRACK_EN
        trk         <= 1'b0;
`endif
      end else begin
        case (state)
          S_SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
              settle_cnt <= '0;
              state      <= S_MEASURE;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_MEASURE: begin
            if (sample_valid) begin
              if (mag > peak) peak <= mag;
              hot_flag <= hot_flag | overload;
              win_cnt  <= win_cnt + 1'b1;
              if (&win_cnt) state <= S_DECIDE;
            end
          end
          S_DECIDE: begin
            // Window statistics restart for whichever state follows.
            peak        <= '0;
            hot_flag    <= 1'b0;
            win_cnt     <= '0;
            settle_cnt  <= '0;
            gain_code   <= next_gain;
            gain_update <= gain_chg;
`ifdef AGC_TRACK_EN
            if (trk) begin
              state <= gain_chg ? S_SETTLE : S_MEASURE;
            end else if (k == '0) begin
              locked <= 1'b1;
              busy   <= 1'b0;
              trk    <= 1'b1;
              state  <= gain_chg ? S_SETTLE : S_MEASURE;
            end else begin
              k     <= k - 1'b1;
              state <= S_SETTLE;
            end
`else
            if (k == '0) begin
              locked <= 1'b1;
              busy   <= 1'b0;
              state  <= S_HOLD;
            end else begin
              k     <= k - 1'b1;
              state <= S_SETTLE;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
